// File: rtl/ahb_simple_master.sv
// Single-outstanding AHB initiator: one command in, one NONSEQ SINGLE transfer out,
// one response back, with bounded RETRY/SPLIT re-issue.
module ahb_simple_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_RETRY  = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR2 = 3'd3;
    localparam logic [2:0] ST_RSP  = 3'd4;

    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam int         RW       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [2:0]            state;
    logic [RW-1:0]         retry_cnt;
    logic [1:0]            resp_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic                  bad_cmd;

    // Oversized or misaligned commands are answered locally without touching the bus.
    assign align_mask = (ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1);
    assign bad_cmd    = (cmd_size > MAX_SIZE) || ((cmd_addr & align_mask) != '0);
    assign HBURST     = 3'b000;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            retry_cnt <= '0;
            resp_q    <= RESP_OKAY;
            wdata_q   <= '0;
            HTRANS    <= TR_IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= 3'd0;
            HWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        wdata_q   <= cmd_wdata;
                        if (bad_cmd) begin
                            state     <= ST_RSP;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state  <= ST_ADDR;
                            HTRANS <= TR_NONSEQ;
                            HADDR  <= cmd_addr;
                            HWRITE <= cmd_write;
                            HSIZE  <= cmd_size;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        state  <= ST_DATA;
                        HTRANS <= TR_IDLE;
                        HWDATA <= HWRITE ? wdata_q : '0;
                    end
                end
                ST_DATA: begin
                    if (HRESP == RESP_OKAY) begin
                        if (HREADY) begin
                            state     <= ST_RSP;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= HWRITE ? '0 : HRDATA;
                        end
                    end else if (HREADY) begin
                        // Single-cycle non-OKAY response is illegal; report it as an error.
                        state     <= ST_RSP;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state  <= ST_ERR2;
                        resp_q <= HRESP;
                    end
                end
                ST_ERR2: begin
                    if (HREADY) begin
                        if (resp_q == RESP_ERROR || retry_cnt >= RW'(MAX_RETRY)) begin
                            state     <= ST_RSP;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= ST_ADDR;
                            retry_cnt <= retry_cnt + 1'b1;
                            HTRANS    <= TR_NONSEQ;
                        end
                    end
                end
                ST_RSP: begin
                    // rsp_valid rises one cycle after entering RSP; data/err are already stable.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        retry_cnt <= '0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b0;
                    HTRANS    <= TR_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_simple_master.sv
// Randomized bench for ahb_simple_master: scripted slave drives the bus, a
// transaction-level model predicts response, issue count and latency.
module tb_ahb_simple_master;
    localparam int AW = 32, DW = 32, MAXR = 4;

    logic          HCLK = 1'b0, HRESETn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [2:0]    cmd_size = 3'd0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE, HBURST;
    logic [DW-1:0] HWDATA, HRDATA = '0;
    logic          HREADY = 1'b1;
    logic [1:0]    HRESP = 2'b00;

    int n_tests = 0, n_fail = 0;

    // per-issue slave script and current command
    int            p_astall[8], p_wait[8];
    logic [1:0]    p_code[8];
    int            p_nretry, p_final;   // final: 0 OKAY, 1 ERROR, 2 one-cycle non-OKAY
    logic [DW-1:0] p_rdata;
    logic [AW-1:0] e_addr;
    logic          e_write;
    logic [2:0]    e_size;
    logic [DW-1:0] e_wdata;
    int            issues = 0, base = 0;

    ahb_simple_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RETRY(MAXR)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Slave: decides HREADY/HRESP/HRDATA for the next rising edge at each falling edge.
    initial begin : slave
        int         ph, stall, wcnt, cur;
        logic [1:0] code;
        ph = 0; stall = 0; wcnt = 0; cur = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                ph = 0; stall = 0; wcnt = 0; HREADY = 1'b1; HRESP = 2'b00;
            end else begin
                case (ph)
                    0: begin
                        HRESP = 2'b00;
                        if (HTRANS == 2'b10) begin
                            cur = issues - base;
                            if (cur > 7) cur = 7;
                            if (stall < p_astall[cur]) begin
                                HREADY = 1'b0;
                                stall++;
                            end else begin
                                check("haddr", HADDR, e_addr);
                                check("hwrite", HWRITE, e_write);
                                check("hsize", HSIZE, e_size);
                                check("hburst", HBURST, 0);
                                HREADY = 1'b1; stall = 0; wcnt = 0; ph = 1;
                                issues++;
                            end
                        end else begin
                            HREADY = 1'b1;
                        end
                    end
                    1: begin
                        if (wcnt == 0) begin
                            check("hwdata", HWDATA, e_write ? e_wdata : 0);
                            check("htrans_data", HTRANS, 0);
                        end
                        if (wcnt < p_wait[cur]) begin
                            HREADY = 1'b0; HRESP = 2'b00; HRDATA = $urandom; wcnt++;
                        end else begin
                            code = (cur < p_nretry) ? p_code[cur] : ((p_final == 1) ? 2'b01 : 2'b00);
                            if (cur >= p_nretry && p_final == 2) begin
                                HREADY = 1'b1; HRESP = 2'($urandom_range(1, 3)); HRDATA = $urandom; ph = 0;
                            end else if (code == 2'b00) begin
                                HREADY = 1'b1; HRESP = 2'b00; HRDATA = p_rdata; ph = 0;
                            end else begin
                                HREADY = 1'b0; HRESP = code; HRDATA = $urandom; ph = 2;
                            end
                        end
                    end
                    default: begin
                        check("htrans_err", HTRANS, 0);
                        HREADY = 1'b1;
                        ph = 0;
                    end
                endcase
            end
        end
    end

    task automatic plan_clear();
        for (int i = 0; i < 8; i++) begin
            p_astall[i] = 0; p_wait[i] = 0; p_code[i] = 2'b10;
        end
        p_nretry = 0; p_final = 0; p_rdata = '0;
    endtask

    task automatic plan_random();
        for (int i = 0; i < 8; i++) begin
            p_astall[i] = ($urandom % 4 == 0) ? $urandom_range(1, 2) : 0;
            p_wait[i]   = $urandom_range(0, 3);
            p_code[i]   = ($urandom % 2 != 0) ? 2'b10 : 2'b11;
        end
        p_nretry = ($urandom % 3 == 0) ? $urandom_range(1, 6) : 0;
        p_final  = $urandom_range(0, 5);
        p_final  = (p_final <= 3) ? 0 : p_final - 3;
        p_rdata  = $urandom;
    endtask

    // Offer the command and return right after its accepting edge.
    task automatic offer(input logic wr, input logic [AW-1:0] addr, input logic [2:0] size,
                         input logic [DW-1:0] wd);
        int n;
        e_addr = addr; e_write = wr; e_size = size; e_wdata = wd; base = issues;
        cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wd; cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!cmd_ready && n < 50);
        check("cmd_accept", cmd_ready, 1);
        @(posedge HCLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [2:0] size,
                           input logic [DW-1:0] wd);
        int            lat, exp_lat, exp_n, hold;
        logic          exp_err, err0;
        logic [DW-1:0] exp_rd, rd0;
        bit            mis;
        // transaction-level expectation
        mis = ((8 << size) > DW) || ((addr % (32'd1 << size)) != 0);
        if (mis) begin
            exp_n = 0; exp_err = 1'b1; exp_lat = 1;
        end else begin
            exp_n   = (p_nretry > MAXR) ? MAXR + 1 : p_nretry + 1;
            exp_err = (p_nretry > MAXR) || (p_final != 0);
            exp_lat = 1;
            for (int i = 0; i < exp_n; i++)
                exp_lat += p_astall[i] + 1 + p_wait[i] + ((i < p_nretry || p_final == 1) ? 2 : 1);
        end
        exp_rd = (!exp_err && !wr) ? p_rdata : '0;

        rsp_ready = 1'($urandom % 2);
        offer(wr, addr, size, wd);
        lat = 0;
        forever begin
            @(negedge HCLK);
            if (rsp_valid || lat >= 300) break;
            lat++;
        end
        check("rsp_latency", lat, exp_lat);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("nonseq_issues", issues - base, exp_n);
        rd0 = rsp_rdata; err0 = rsp_err;
        if (!rsp_ready) begin
            hold = $urandom_range(1, 3);
            repeat (hold) begin
                @(negedge HCLK);
                check("rsp_hold", {rsp_valid, err0 ^ rsp_err, rsp_rdata}, {1'b1, 1'b0, rd0});
            end
            rsp_ready = 1'b1;
        end
        @(posedge HCLK);
        #1;
        check("rsp_handshake", {rsp_valid, cmd_ready}, 2'b01);
        rsp_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bus"}, {HTRANS, HWRITE, HSIZE, HBURST, HADDR}, 0);
        check({tag, "_hwdata"}, HWDATA, 0);
        check({tag, "_rsp"}, {rsp_valid, rsp_err, cmd_ready, rsp_rdata}, 0);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [2:0]    sz;
        plan_clear();
        e_addr = '0; e_write = 1'b0; e_size = 3'd0; e_wdata = '0;
        repeat (3) @(negedge HCLK);
        check_reset_vals("reset");
        HRESETn = 1'b1;
        #1 check("cmd_ready_in_reset_exit", cmd_ready, 0);
        @(posedge HCLK);
        #1 check("cmd_ready_rise", cmd_ready, 1);

        // directed scenarios
        plan_clear();
        run_cmd(1'b1, 32'h0000_1000, 3'd2, 32'hDEAD_BEEF);
        plan_clear(); p_wait[0] = 3; p_rdata = 32'h1234_5678;
        run_cmd(1'b0, 32'h0000_1004, 3'd2, '0);
        plan_clear(); p_final = 1;
        run_cmd(1'b0, 32'hF000_0000, 3'd2, '0);
        plan_clear(); p_nretry = 5;
        run_cmd(1'b0, 32'h0000_2000, 3'd2, '0);
        plan_clear(); p_nretry = 4; p_rdata = 32'hCAFE_F00D;
        run_cmd(1'b0, 32'h0000_2004, 3'd2, '0);
        plan_clear();
        run_cmd(1'b0, 32'h0000_1002, 3'd2, '0);
        plan_clear(); p_final = 2;
        run_cmd(1'b1, 32'h0000_2008, 3'd1, 32'h0BAD_0BAD);
        plan_clear();
        run_cmd(1'b0, 32'h0000_2010, 3'd3, '0);

        // reset in the middle of a data phase
        plan_clear(); p_wait[0] = 10;
        offer(1'b1, 32'h0000_3000, 3'd2, 32'hA5A5_5A5A);
        repeat (3) @(negedge HCLK);
        check("mid_hwdata", HWDATA, 32'hA5A5_5A5A);
        #2 HRESETn = 1'b0;
        #1 check_reset_vals("mid_reset");
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1 check("cmd_ready_after_mid_reset", cmd_ready, 1);
        plan_clear(); p_rdata = 32'h7777_0001;
        run_cmd(1'b0, 32'h0000_3004, 3'd2, '0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            plan_random();
            sz = ($urandom % 8 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom % 5 != 0) a = a & ~((32'd1 << sz) - 32'd1);
            run_cmd(1'($urandom % 2), a, sz, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
